pat_serial_gen: RTL and testbench

- Serial pattern transmitter. It is the driving end of the serial pattern-detection path.
- Captures a SIZE-bit pattern plus a repeat count and an inter-frame gap through a valid/ready load handshake.
- Shifts the pattern out MSB-first, one bit per clock, on a single-bit stream consumed by the pattern detectors.
- Used as stimulus source and as the on-chip frame sender.

---
 rtl/pat_serial_gen.sv | 145 ++++++++++++++
 tb/tb_pat_serial_gen.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pat_serial_gen.sv
// Serial pattern transmitter: loads a SIZE-bit pattern, repeat count and gap,
// then shifts the pattern out MSB-first with optional idle gaps between frames.
module pat_serial_gen #(
  parameter int SIZE  = 5,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIZE-1:0]  pat_in,
  input  logic [CNT_W-1:0] rep_in,
  input  logic [GAP_W-1:0] gap_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [SIZE-1:0]  r_pat;
  logic [CNT_W-1:0] r_rem;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [IDX_W-1:0] r_bit_idx;

  logic             w_accept;
  logic             w_last_frame;
  logic [IDX_W-1:0] w_next_idx;

  assign w_accept     = load_valid & load_ready;
  assign w_last_frame = (r_rem == CNT_W'(1));
  assign w_next_idx   = r_bit_idx - IDX_W'(1);

  // Transaction FSM; every output is registered and reflects the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pat       <= {SIZE{1'b0}};
      r_rem       <= {CNT_W{1'b0}};
      r_gap       <= {GAP_W{1'b0}};
      r_gap_cnt   <= {GAP_W{1'b0}};
      r_bit_idx   <= {IDX_W{1'b0}};
      load_ready  <= 1'b1;
      out         <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      out         <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pat      <= pat_in;
            r_rem      <= rep_in;
            r_gap      <= gap_in;
            load_ready <= 1'b0;
            busy       <= 1'b1;
            if (rep_in == {CNT_W{1'b0}}) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              r_state     <= S_SEND;
              r_bit_idx   <= LAST_IDX;
              out         <= pat_in[SIZE-1];
              out_valid   <= 1'b1;
              frame_start <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SEND: begin
          if (abort) begin
            r_state    <= S_IDLE;
            load_ready <= 1'b1;
            busy       <= 1'b0;
          end else if (r_bit_idx != {IDX_W{1'b0}}) begin
            r_bit_idx <= w_next_idx;
            out       <= r_pat[w_next_idx];
            out_valid <= 1'b1;
          end else begin
            r_rem <= r_rem - CNT_W'(1);
            if (w_last_frame) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else if (r_gap != {GAP_W{1'b0}}) begin
              r_state   <= S_GAP;
              r_gap_cnt <= r_gap;
            end else begin
              // Back-to-back frame: restart at the MSB with no idle bubble.
              r_bit_idx   <= LAST_IDX;
              out         <= r_pat[SIZE-1];
              out_valid   <= 1'b1;
              frame_start <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (abort) begin
            r_state    <= S_IDLE;
            load_ready <= 1'b1;
            busy       <= 1'b0;
          end else if (r_gap_cnt == GAP_W'(1)) begin
            r_state     <= S_SEND;
            r_bit_idx   <= LAST_IDX;
            out         <= r_pat[SIZE-1];
            out_valid   <= 1'b1;
            frame_start <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          load_ready <= 1'b1;
          busy       <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          load_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pat_serial_gen.sv
// Directed self-checking bench for pat_serial_gen; observations are packed as
// {out_valid, out, frame_start, busy, done, load_ready}.
module tb_pat_serial_gen;

  localparam int SIZE  = 5;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [SIZE-1:0]  pat_in = '0;
  logic [CNT_W-1:0] rep_in = '0;
  logic [GAP_W-1:0] gap_in = '0;
  logic             load_valid = 1'b0;
  logic             abort = 1'b0;
  logic             load_ready, out, out_valid, frame_start, busy, done;

  int tests_run = 0;
  int failed = 0;

  logic [5:0] obs;
  assign obs = {out_valid, out, frame_start, busy, done, load_ready};

  localparam logic [5:0] OBS_IDLE = 6'b000001;
  localparam logic [5:0] OBS_GAP  = 6'b000100;
  localparam logic [5:0] OBS_DONE = 6'b000110;

  always #5 clk = ~clk;

  pat_serial_gen #(.SIZE(SIZE), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .pat_in(pat_in), .rep_in(rep_in), .gap_in(gap_in),
    .load_valid(load_valid), .load_ready(load_ready), .abort(abort),
    .out(out), .out_valid(out_valid), .frame_start(frame_start),
    .busy(busy), .done(done)
  );

  // Reference 5-bit detector for pattern 11011 fed by the valid serial stream.
  logic       det_clr = 1'b0;
  logic [3:0] det_sh;
  int         det_hits;
  always @(negedge clk) begin
    if (det_clr) begin
      det_sh   <= 4'b0000;
      det_hits <= 0;
    end else if (out_valid) begin
      det_sh <= {det_sh[2:0], out};
      if ({det_sh, out} == 5'b11011) det_hits <= det_hits + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [SIZE-1:0] p, input logic [CNT_W-1:0] r,
                      input logic [GAP_W-1:0] g);
    pat_in = p; rep_in = r; gap_in = g; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    tests_run++;
    if (obs !== OBS_IDLE) begin
      failed++;
      $display("FAIL reset_async: got %b expected %b", obs, OBS_IDLE);
    end
    step(); step();
    rst = 1'b1;
    step();
    tests_run++;
    if (obs !== OBS_IDLE) begin
      failed++;
      $display("FAIL reset_idle: got %b expected %b", obs, OBS_IDLE);
    end
  endtask

  task automatic test_single();
    logic [4:0] p = 5'b11011;
    logic [5:0] exp;
    load(p, 8'd1, 4'd0);
    for (int i = 0; i < 5; i++) begin
      exp = {1'b1, p[4-i], (i == 0), 3'b100};
      tests_run++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL single bit%0d: got %b expected %b", i, obs, exp);
      end
      step();
    end
    tests_run++;
    if (obs !== OBS_DONE) begin
      failed++;
      $display("FAIL single done: got %b expected %b", obs, OBS_DONE);
    end
    step();
    tests_run++;
    if (obs !== OBS_IDLE) begin
      failed++;
      $display("FAIL single idle: got %b expected %b", obs, OBS_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] p = 5'b11011;
    logic [5:0] exp;
    det_clr = 1'b1;
    step();
    det_clr = 1'b0;
    load(p, 8'd2, 4'd0);
    for (int i = 0; i < 10; i++) begin
      exp = {1'b1, p[4-(i%5)], ((i % 5) == 0), 3'b100};
      tests_run++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL b2b bit%0d: got %b expected %b", i, obs, exp);
      end
      step();
    end
    tests_run++;
    if (obs !== OBS_DONE) begin
      failed++;
      $display("FAIL b2b done: got %b expected %b", obs, OBS_DONE);
    end
    step();
    tests_run++;
    if (det_hits !== 2) begin
      failed++;
      $display("FAIL b2b detector_hits: got %0d expected 2", det_hits);
    end
  endtask

  task automatic test_gap();
    logic [4:0] p = 5'b10010;
    logic [5:0] exp;
    int fs_cnt = 0;
    int done_cnt = 0;
    int ph;
    load(p, 8'd3, 4'd2);
    pat_in = 5'b11111; rep_in = 8'd9; gap_in = 4'd0;
    for (int c = 0; c < 19; c++) begin
      ph  = c % 7;
      exp = (ph < 5) ? {1'b1, p[4-ph], (ph == 0), 3'b100} : OBS_GAP;
      fs_cnt   += int'(frame_start);
      done_cnt += int'(done);
      tests_run++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL gap cycle%0d: got %b expected %b", c, obs, exp);
      end
      step();
    end
    done_cnt += int'(done);
    tests_run++;
    if (obs !== OBS_DONE) begin
      failed++;
      $display("FAIL gap done: got %b expected %b", obs, OBS_DONE);
    end
    step();
    done_cnt += int'(done);
    tests_run++;
    if (fs_cnt !== 3 || done_cnt !== 1) begin
      failed++;
      $display("FAIL gap counts: got fs=%0d done=%0d expected fs=3 done=1", fs_cnt, done_cnt);
    end
  endtask

  task automatic test_rep_zero();
    load(5'b10101, 8'd0, 4'd5);
    tests_run++;
    if (obs !== OBS_DONE) begin
      failed++;
      $display("FAIL rep0 done: got %b expected %b", obs, OBS_DONE);
    end
    step();
    tests_run++;
    if (obs !== OBS_IDLE) begin
      failed++;
      $display("FAIL rep0 idle: got %b expected %b", obs, OBS_IDLE);
    end
  endtask

  task automatic test_ignore_load();
    logic [4:0] p = 5'b11011;
    logic [5:0] exp;
    load(p, 8'd1, 4'd0);
    for (int i = 0; i < 5; i++) begin
      exp = {1'b1, p[4-i], (i == 0), 3'b100};
      tests_run++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL ignore bit%0d: got %b expected %b", i, obs, exp);
      end
      pat_in = 5'b00100; rep_in = 8'd3; load_valid = 1'b1;
      step();
    end
    load_valid = 1'b0;
    tests_run++;
    if (obs !== OBS_DONE) begin
      failed++;
      $display("FAIL ignore done: got %b expected %b", obs, OBS_DONE);
    end
    step(); step();
    tests_run++;
    if (obs !== OBS_IDLE) begin
      failed++;
      $display("FAIL ignore no_queue: got %b expected %b", obs, OBS_IDLE);
    end
  endtask

  task automatic test_abort();
    logic [4:0] p = 5'b11011;
    logic [4:0] q = 5'b01101;
    logic [5:0] exp;
    load(p, 8'd4, 4'd0);
    for (int i = 0; i < 3; i++) begin
      exp = {1'b1, p[4-i], (i == 0), 3'b100};
      tests_run++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL abort bit%0d: got %b expected %b", i, obs, exp);
      end
      if (i < 2) step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (obs !== OBS_IDLE) begin
        failed++;
        $display("FAIL abort idle%0d: got %b expected %b", i, obs, OBS_IDLE);
      end
      step();
    end
    abort = 1'b1;
    load(q, 8'd1, 4'd0);
    abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp = {1'b1, q[4-i], (i == 0), 3'b100};
      tests_run++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL abort_load bit%0d: got %b expected %b", i, obs, exp);
      end
      step();
    end
    tests_run++;
    if (obs !== OBS_DONE) begin
      failed++;
      $display("FAIL abort_load done: got %b expected %b", obs, OBS_DONE);
    end
    step();
  endtask

  task automatic test_async_reset();
    load(5'b11011, 8'd2, 4'd3);
    for (int i = 0; i < 5; i++) step();
    tests_run++;
    if (obs !== OBS_GAP) begin
      failed++;
      $display("FAIL async in_gap: got %b expected %b", obs, OBS_GAP);
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (obs !== OBS_IDLE) begin
      failed++;
      $display("FAIL async no_edge: got %b expected %b", obs, OBS_IDLE);
    end
    step(); step();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      tests_run++;
      if (obs !== OBS_IDLE) begin
        failed++;
        $display("FAIL async lost%0d: got %b expected %b", i, obs, OBS_IDLE);
      end
    end
  endtask

  task automatic test_rep_max();
    int n = 0;
    int vcnt = 0;
    int fcnt = 0;
    load(5'b10110, 8'd255, 4'd0);
    while (!done && n < 2000) begin
      vcnt += int'(out_valid);
      fcnt += int'(frame_start);
      step();
      n++;
    end
    tests_run++;
    if (done !== 1'b1 || vcnt !== 1275 || fcnt !== 255) begin
      failed++;
      $display("FAIL rep_max: got done=%b bits=%0d frames=%0d expected done=1 bits=1275 frames=255",
               done, vcnt, fcnt);
    end
    step();
    tests_run++;
    if (obs !== OBS_IDLE) begin
      failed++;
      $display("FAIL rep_max idle: got %b expected %b", obs, OBS_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_rep_zero();
    test_ignore_load();
    test_abort();
    test_async_reset();
    test_rep_max();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
